// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters, a one-stage coordinate output, and a sync group
// (hs, vs, blank, strobes) delayed by LEAD extra ce-cycles to cover downstream read latency.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned LEAD     = 0,
    parameter int unsigned CW       = 11,
    parameter int unsigned FC_W     = 16
) (
    input  logic            pixel_clk,
    input  logic            rst,
    input  logic            ce,
    output logic [CW-1:0]   drawX,
    output logic [CW-1:0]   drawY,
    output logic            de_early,
    output logic            hs,
    output logic            vs,
    output logic            blank,
    output logic            line_start,
    output logic            frame_start,
    output logic [FC_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END    = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END    = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned STAGES    = LEAD + 1;

    // Sync group packing: {hs, vs, blank, line_start, frame_start}
    localparam logic [4:0] SYNC_RST = {~HS_POL, ~VS_POL, 1'b1, 1'b0, 1'b0};

    logic [CW-1:0]         hc_q;
    logic [CW-1:0]         vc_q;
    logic                  hc_last;
    logic                  vc_last;
    logic                  active;
    logic                  hsync_on;
    logic                  vsync_on;
    logic [4:0]            sync_in;
    logic [STAGES*5-1:0]   sync_q;

    always_comb begin
        hc_last  = (hc_q == CW'(H_TOTAL - 1));
        vc_last  = (vc_q == CW'(V_TOTAL - 1));
        active   = (hc_q < CW'(H_ACTIVE)) && (vc_q < CW'(V_ACTIVE));
        hsync_on = (hc_q >= CW'(HS_START)) && (hc_q < CW'(HS_END));
        vsync_on = (vc_q >= CW'(VS_START)) && (vc_q < CW'(VS_END));
        sync_in  = {hsync_on ? HS_POL : ~HS_POL,
                    vsync_on ? VS_POL : ~VS_POL,
                    ~active,
                    hc_q == '0,
                    (hc_q == '0) && (vc_q == '0)};
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hc_q     <= '0;
            vc_q     <= '0;
            drawX    <= '0;
            drawY    <= '0;
            de_early <= 1'b0;
        end else if (ce) begin
            hc_q <= hc_last ? '0 : hc_q + 1'b1;
            if (hc_last) begin
                vc_q <= vc_last ? '0 : vc_q + 1'b1;
            end
            drawX    <= active ? hc_q : '0;
            drawY    <= active ? vc_q : '0;
            de_early <= active;
        end
    end

    if (LEAD == 0) begin : g_no_lead
        always_ff @(posedge pixel_clk) begin
            if (rst) begin
                sync_q <= SYNC_RST;
            end else if (ce) begin
                sync_q <= sync_in;
            end
        end
    end else begin : g_lead
        always_ff @(posedge pixel_clk) begin
            if (rst) begin
                sync_q <= {STAGES{SYNC_RST}};
            end else if (ce) begin
                sync_q <= {sync_q[LEAD*5-1:0], sync_in};
            end
        end
    end

    assign {hs, vs, blank, line_start, frame_start} = sync_q[STAGES*5-1 -: 5];

    // Counts frame_start as seen at the output, so it lags the strobe by one ce-cycle.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (ce && frame_start) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen: a default-size instance plus two small-raster
// instances (LEAD=0, and LEAD=3 with active-high syncs) driven by a shared rst/ce.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    logic pixel_clk = 1'b0;
    logic rst = 1'b1;
    logic ce = 1'b0;

    always #5 pixel_clk = ~pixel_clk;

    logic [10:0] x0, y0, x1, y1, x2, y2;
    logic        de0, hs0, vs0, bl0, ls0, fs0;
    logic        de1, hs1, vs1, bl1, ls1, fs1;
    logic        de2, hs2, vs2, bl2, ls2, fs2;
    logic [15:0] fc0, fc1, fc2;
    obs_t        o0, o1, o2;

    assign o0 = {x0, y0, de0, hs0, vs0, bl0, ls0, fs0, fc0};
    assign o1 = {x1, y1, de1, hs1, vs1, bl1, ls1, fs1, fc1};
    assign o2 = {x2, y2, de2, hs2, vs2, bl2, ls2, fs2, fc2};

    vga_timing_gen u_d0 (
        .pixel_clk(pixel_clk), .rst(rst), .ce(ce),
        .drawX(x0), .drawY(y0), .de_early(de0), .hs(hs0), .vs(vs0), .blank(bl0),
        .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_d1 (
        .pixel_clk(pixel_clk), .rst(rst), .ce(ce),
        .drawX(x1), .drawY(y1), .de_early(de1), .hs(hs1), .vs(vs1), .blank(bl1),
        .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .LEAD(3)
    ) u_d2 (
        .pixel_clk(pixel_clk), .rst(rst), .ce(ce),
        .drawX(x2), .drawY(y2), .de_early(de2), .hs(hs2), .vs(vs2), .blank(bl2),
        .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2)
    );

    int     n_pass = 0;
    int     n_total = 0;
    longint k = 0;
    obs_t   q0[$];
    obs_t   q1[$];
    obs_t   q2[$];

    // Expected outputs after k ce-edges since reset, from closed-form raster positions.
    function automatic obs_t model(int ha, int hf, int hsw, int hb, int va, int vf, int vsw,
                                   int vb, int lead, bit hpol, bit vpol, longint kk);
        obs_t   o;
        longint ht, vt, fl, n, hc, vc, m;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        fl = ht * vt;
        o = '0;
        o.hs = !hpol;
        o.vs = !vpol;
        o.blank = 1'b1;
        if (kk >= 1) begin
            n = kk - 1;
            hc = n % ht;
            vc = (n / ht) % vt;
            if (hc < ha && vc < va) begin
                o.x = 11'(hc);
                o.y = 11'(vc);
                o.de = 1'b1;
            end
        end
        if (kk - 1 - lead >= 0) begin
            n = kk - 1 - lead;
            hc = n % ht;
            vc = (n / ht) % vt;
            o.blank = !(hc < ha && vc < va);
            o.hs = (hc >= ha + hf && hc < ha + hf + hsw) ? hpol : !hpol;
            o.vs = (vc >= va + vf && vc < va + vf + vsw) ? vpol : !vpol;
            o.ls = (hc == 0);
            o.fs = (n % fl == 0);
        end
        m = kk - 2 - lead;
        if (m >= 0) o.fc = 16'(m / fl + 1);
        return o;
    endfunction

    task automatic cycle(input bit r, input bit c);
        rst = r;
        ce = c;
        if (r) k = 0;
        else if (c) k++;
        q0.push_back(model(640, 16, 96, 48, 480, 10, 2, 33, 0, 1'b0, 1'b0, k));
        q1.push_back(model(8, 2, 3, 2, 4, 1, 2, 1, 0, 1'b0, 1'b0, k));
        q2.push_back(model(8, 2, 3, 2, 4, 1, 2, 1, 3, 1'b1, 1'b1, k));
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e0, e1, e2;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, i[0]);
            e0 = q0.pop_front(); e1 = q1.pop_front(); e2 = q2.pop_front();
            n_total++; if (o0 !== e0) $display("FAIL reset_d0 got=%h exp=%h", o0, e0); else n_pass++;
            n_total++; if (o1 !== e1) $display("FAIL reset_d1 got=%h exp=%h", o1, e1); else n_pass++;
            n_total++; if (o2 !== e2) $display("FAIL reset_d2 got=%h exp=%h", o2, e2); else n_pass++;
        end
    endtask

    task automatic test_line_and_frame();
        obs_t e0, e1, e2;
        int hs_low = 0, first_hs = 0, blank_hi = 0, ls_cnt = 0;
        int vs_low1 = 0, first_vs1 = 0, blank_hi1 = 0;
        for (int i = 1; i <= 1700; i++) begin
            cycle(1'b0, 1'b1);
            e0 = q0.pop_front(); e1 = q1.pop_front(); e2 = q2.pop_front();
            n_total++; if (o0 !== e0) $display("FAIL run_d0 got=%h exp=%h", o0, e0); else n_pass++;
            n_total++; if (o1 !== e1) $display("FAIL run_d1 got=%h exp=%h", o1, e1); else n_pass++;
            n_total++; if (o2 !== e2) $display("FAIL run_d2 got=%h exp=%h", o2, e2); else n_pass++;
            if (i == 1) begin
                n_total++;
                if ({x0, bl0, fs0, ls0} !== {11'd0, 1'b0, 1'b1, 1'b1})
                    $display("FAIL first_pixel got=%b exp=%b", {x0, bl0, fs0, ls0},
                             {11'd0, 1'b0, 1'b1, 1'b1});
                else n_pass++;
            end
            if (i == 640) begin
                n_total++; if (x0 !== 11'd639) $display("FAIL last_active_x got=%0d exp=639", x0);
                else n_pass++;
            end
            if (i == 641) begin
                n_total++; if (x0 !== 11'd0) $display("FAIL after_active_x got=%0d exp=0", x0);
                else n_pass++;
            end
            if (i == 2 || i == 122) begin
                n_total++;
                if (fc1 !== ((i == 2) ? 16'd1 : 16'd2))
                    $display("FAIL frame_cnt_d1 got=%0d exp=%0d", fc1, (i == 2) ? 1 : 2);
                else n_pass++;
            end
            if (ls0) ls_cnt++;
            if (i <= 800) begin
                if (!hs0) hs_low++;
                if (!hs0 && first_hs == 0) first_hs = i;
                if (bl0) blank_hi++;
            end
            if (i <= 120) begin
                if (!vs1) vs_low1++;
                if (!vs1 && first_vs1 == 0) first_vs1 = i;
                if (bl1) blank_hi1++;
            end
        end
        n_total++; if (hs_low !== 96) $display("FAIL hs_low_len got=%0d exp=96", hs_low); else n_pass++;
        n_total++; if (first_hs !== 657) $display("FAIL hs_start got=%0d exp=657", first_hs); else n_pass++;
        n_total++; if (blank_hi !== 160) $display("FAIL h_blank_len got=%0d exp=160", blank_hi); else n_pass++;
        n_total++; if (ls_cnt !== 3) $display("FAIL line_start_cnt got=%0d exp=3", ls_cnt); else n_pass++;
        n_total++; if (vs_low1 !== 30) $display("FAIL vs_low_len got=%0d exp=30", vs_low1); else n_pass++;
        n_total++; if (first_vs1 !== 76) $display("FAIL vs_start got=%0d exp=76", first_vs1); else n_pass++;
        n_total++; if (blank_hi1 !== 88) $display("FAIL v_blank_len got=%0d exp=88", blank_hi1); else n_pass++;
    endtask

    task automatic test_lead();
        obs_t e0, e1, e2;
        int   de_rise = 0, falls = 0, hs_hi = 0;
        logic prev_de = 1'b0, prev_bl = 1'b1;
        cycle(1'b1, 1'b1);
        void'(q0.pop_front()); void'(q1.pop_front());
        e2 = q2.pop_front();
        n_total++; if (o2 !== e2) $display("FAIL lead_reset got=%h exp=%h", o2, e2); else n_pass++;
        for (int i = 1; i <= 300; i++) begin
            cycle(1'b0, 1'b1);
            e0 = q0.pop_front(); e1 = q1.pop_front(); e2 = q2.pop_front();
            n_total++; if (o0 !== e0) $display("FAIL lead_d0 got=%h exp=%h", o0, e0); else n_pass++;
            n_total++; if (o1 !== e1) $display("FAIL lead_d1 got=%h exp=%h", o1, e1); else n_pass++;
            n_total++; if (o2 !== e2) $display("FAIL lead_d2 got=%h exp=%h", o2, e2); else n_pass++;
            if (i == 3) begin
                n_total++; if ({fs2, bl2} !== 2'b01) $display("FAIL lead_hold got=%b exp=01", {fs2, bl2});
                else n_pass++;
            end
            if (i == 4) begin
                n_total++; if ({fs2, ls2} !== 2'b11) $display("FAIL lead_strobe got=%b exp=11", {fs2, ls2});
                else n_pass++;
            end
            if (i == 6) begin
                n_total++; if (x2 !== 11'd5) $display("FAIL lead_x_at_hc2 got=%0d exp=5", x2);
                else n_pass++;
            end
            if (i >= 4 && i <= 18 && hs2) hs_hi++;
            if (de2 && !prev_de) de_rise = i;
            if (!bl2 && prev_bl) begin
                falls++;
                n_total++;
                if (i - de_rise !== 3) $display("FAIL lead_gap got=%0d exp=3", i - de_rise);
                else n_pass++;
            end
            prev_de = de2;
            prev_bl = bl2;
        end
        n_total++; if (falls !== 12) $display("FAIL lead_falls got=%0d exp=12", falls); else n_pass++;
        n_total++; if (hs_hi !== 3) $display("FAIL hs_pol_high got=%0d exp=3", hs_hi); else n_pass++;
    endtask

    task automatic test_ce_gaps();
        obs_t   e0, e1, e2;
        bit     c;
        logic   prev_ls0 = 1'b0, prev_ls2 = 1'b0;
        longint last0 = -1, last2 = -1;
        for (int i = 0; i < 3400; i++) begin
            c = (i % 4 == 0) || (i % 4 == 3);
            cycle(1'b0, c);
            e0 = q0.pop_front(); e1 = q1.pop_front(); e2 = q2.pop_front();
            n_total++; if (o0 !== e0) $display("FAIL gap_d0 got=%h exp=%h", o0, e0); else n_pass++;
            n_total++; if (o1 !== e1) $display("FAIL gap_d1 got=%h exp=%h", o1, e1); else n_pass++;
            n_total++; if (o2 !== e2) $display("FAIL gap_d2 got=%h exp=%h", o2, e2); else n_pass++;
            if (!c && prev_ls0) begin
                n_total++; if (ls0 !== 1'b1) $display("FAIL strobe_hold got=%b exp=1", ls0);
                else n_pass++;
            end
            if (ls0 && !prev_ls0) begin
                if (last0 >= 0) begin
                    n_total++;
                    if (k - last0 !== 800) $display("FAIL gap_line_len got=%0d exp=800", k - last0);
                    else n_pass++;
                end
                last0 = k;
            end
            if (ls2 && !prev_ls2) begin
                if (last2 >= 0) begin
                    n_total++;
                    if (k - last2 !== 15) $display("FAIL gap_line_len_d2 got=%0d exp=15", k - last2);
                    else n_pass++;
                end
                last2 = k;
            end
            prev_ls0 = ls0;
            prev_ls2 = ls2;
        end
    endtask

    task automatic test_mid_reset();
        obs_t e0, e1, e2;
        for (int i = 0; i < 120 && (k % 120) != 50; i++) begin
            cycle(1'b0, 1'b1);
            e0 = q0.pop_front(); e1 = q1.pop_front(); e2 = q2.pop_front();
            n_total++; if (o1 !== e1) $display("FAIL pre_rst_d1 got=%h exp=%h", o1, e1); else n_pass++;
        end
        cycle(1'b1, 1'b0);
        e0 = q0.pop_front(); e1 = q1.pop_front(); e2 = q2.pop_front();
        n_total++; if (o0 !== e0) $display("FAIL midrst_d0 got=%h exp=%h", o0, e0); else n_pass++;
        n_total++; if (o1 !== e1) $display("FAIL midrst_d1 got=%h exp=%h", o1, e1); else n_pass++;
        n_total++; if (o2 !== e2) $display("FAIL midrst_d2 got=%h exp=%h", o2, e2); else n_pass++;
        n_total++; if (fc1 !== 16'd0) $display("FAIL midrst_fc got=%0d exp=0", fc1); else n_pass++;
        for (int i = 1; i <= 250; i++) begin
            cycle(1'b0, 1'b1);
            e0 = q0.pop_front(); e1 = q1.pop_front(); e2 = q2.pop_front();
            n_total++; if (o0 !== e0) $display("FAIL post_d0 got=%h exp=%h", o0, e0); else n_pass++;
            n_total++; if (o1 !== e1) $display("FAIL post_d1 got=%h exp=%h", o1, e1); else n_pass++;
            n_total++; if (o2 !== e2) $display("FAIL post_d2 got=%h exp=%h", o2, e2); else n_pass++;
            if (i == 1) begin
                n_total++;
                if ({x1, y1, fs1} !== {11'd0, 11'd0, 1'b1})
                    $display("FAIL restart_origin got=%h exp=%h", {x1, y1, fs1}, {11'd0, 11'd0, 1'b1});
                else n_pass++;
            end
            if (i == 2) begin
                n_total++; if (fc1 !== 16'd1) $display("FAIL restart_fc got=%0d exp=1", fc1);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_and_frame();
        test_lead();
        test_ce_gaps();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the pixel-clock domain. It supports any resolution through porch and sync parameters, programmable sync polarity, and a pixel clock-enable. It adds line-start and frame-start strobes, a frame counter, and a configurable coordinate lead (`LEAD`) so that drawX/drawY arrive ahead of hs/vs/blank to cover downstream frame-buffer or ROM read latency. It drives the video DAC/HDMI encoder and feeds coordinates to the pixel-generation logic.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hs (0 = active-low)
- VS_POL, 0, asserted level of vs (0 = active-low)
- LEAD, 0, number of ce-cycles (0..7) by which coordinates lead the sync group
- CW, 11, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- FC_W, 16, frame counter width

Ports:
- pixel_clk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- ce  in  1  pixel advance enable; all state holds when 0
- drawX  out  CW  column of the current pixel, 0 outside the active region
- drawY  out  CW  row of the current pixel, 0 outside the active region
- de_early  out  1  1 when drawX/drawY are inside the active region (coordinate-aligned)
- hs  out  1  horizontal sync at HS_POL level while asserted
- vs  out  1  vertical sync at VS_POL level while asserted
- blank  out  1  1 outside the active region (sync-aligned)
- line_start  out  1  high for the pixel at hc=0 of every line (sync-aligned)
- frame_start  out  1  high for the pixel at hc=0, vc=0 (sync-aligned)
- frame_cnt  out  FC_W  completed frame_start count, modulo 2^FC_W

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
- Line order is active, front porch, sync, back porch. The same order applies to frames.
- Counters hc and vc advance only on edges where ce=1.
  - hc wraps from H_TOTAL-1 to 0.
  - vc increments only when hc wraps, and wraps from V_TOTAL-1 to 0.
- Region decode for counter state (hc,vc):
  - active = hc<H_ACTIVE && vc<V_ACTIVE
  - hsync_on = H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC
  - vsync_on = V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC. This decodes on vc only, so vs changes at hc=0 of the line.
- Coordinate stage is one register stage:
  - drawX = active ? hc : 0
  - drawY = active ? vc : 0
  - de_early = active
- Sync group is hs, vs, blank, line_start and frame_start.
  - It passes through 1+LEAD register stages. All stages advance only on ce.
  - hs = hsync_on ? HS_POL : ~HS_POL. vs is formed the same way from vsync_on and VS_POL.
- frame_cnt increments by 1 on each ce=1 edge at which the frame_start output is 1. It wraps modulo 2^FC_W.
- While ce=0, every output holds. A strobe therefore stays high until the next ce=1 edge.
- rst has priority over ce and takes effect on the next edge regardless of position. Reset clears all pipeline stages and restarts at (0,0).

## Timing
- Reset values:
  - hc=vc=0
  - drawX=drawY=0, de_early=0
  - hs=~HS_POL, vs=~VS_POL
  - blank=1
  - line_start=frame_start=0
  - frame_cnt=0
- Coordinate latency is 1 ce-cycle from counter state to drawX/drawY/de_early.
- Sync group latency is 1+LEAD ce-cycles. It lags the coordinates by exactly LEAD ce-cycles.
- After rst falls with ce held at 1:
  - The first edge presents (0,0) on the coordinates.
  - frame_start and line_start rise LEAD edges later, for one cycle.
  - During the first LEAD cycles the sync group keeps its reset values.
- Each line is H_TOTAL ce-cycles and each frame is H_TOTAL*V_TOTAL ce-cycles. Timing is not affected by gaps in ce.

## Test plan
- Defaults, LEAD=0, ce=1, release reset:
  - Cycle 1: drawX=0, blank=0, frame_start=1, line_start=1.
  - line_start repeats every 800 cycles.
  - frame_start repeats every 420000 cycles.
  - frame_cnt reads 1 after the first frame_start and 2 after the second.
- Defaults, one line:
  - hs low exactly for hc 656..751 (96 cycles).
  - blank high for hc 640..799.
  - drawX=639 on the last active pixel, then 0.
- Defaults, one frame:
  - vs low for vc 490..491, i.e. 1600 cycles starting at hc=0.
  - blank stays high for all of vc 480..524.
- LEAD=3:
  - de_early rises 3 cycles before blank falls on every line.
  - drawX=5 coincides with the sync-group pixel for hc=2.
- ce toggling 1,0,0,1 pattern, and HS_POL=1:
  - Line length is 800 ce-cycles.
  - Strobes hold high through ce=0 gaps.
  - hs is high during sync.
- Assert rst mid-frame (vc=300, hc=400):
  - The next edge gives reset values.
  - After release, sequencing restarts at (0,0) and frame_cnt restarts from 0.
